ysyx_25030093_wb_arbiter: RTL and testbench

- Shares the single register-file write port (wen/waddr/wdata) between two writeback requesters: EXU (ALU results) and LSU (load data).
- Each requester uses a valid/ready handshake.
- Keeps a pending-write scoreboard so the decode stage can stall on a read-after-write hazard for rs1.
- Sits between EXU/LSU and the register file.

---
 rtl/ysyx_25030093_wb_arbiter.sv | 70 +++++++
 tb/tb_ysyx_25030093_wb_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25030093_wb_arbiter.sv
// ysyx_25030093_wb_arbiter: round-robin EXU/LSU arbiter for the register-file write port,
// with a pending-write scoreboard that lets decode stall on rs1 hazards.
module ysyx_25030093_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    output logic                  rs1_busy,
    output logic                  idle
);
    localparam int REGS = 2 ** ADDR_WIDTH;

    logic                  prio_lsu;
    logic [REGS-1:0]       busy;
    logic [REGS-1:0]       busy_next;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    // prio_lsu is set after an EXU grant, so a lone contender always wins and ties alternate
    assign exu_ready = exu_valid && (!lsu_valid || !prio_lsu);
    assign lsu_ready = lsu_valid && (!exu_valid || prio_lsu);
    assign xfer      = exu_ready || lsu_ready;
    assign sel_rd    = lsu_ready ? lsu_rd : exu_rd;
    assign sel_data  = lsu_ready ? lsu_data : exu_data;

    // Clear first so a same-cycle issue to the retiring register stays pending
    always_comb begin
        busy_next = busy;
        if (rf_wen) busy_next[rf_waddr] = 1'b0;
        if (issue_valid) busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_lsu <= 1'b0;
            busy     <= '0;
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            busy   <= busy_next;
            rf_wen <= xfer && sel_rd != '0;
            if (xfer) begin
                prio_lsu <= exu_ready;
                rf_waddr <= sel_rd;
                rf_wdata <= sel_data;
            end
        end
    end

    assign rs1_busy = busy[rs1_addr];
    assign idle     = busy == '0 && !rf_wen;
endmodule

// File: tb/tb_ysyx_25030093_wb_arbiter.sv
// tb_ysyx_25030093_wb_arbiter: randomized + directed bench; a reference model predicts grants,
// rf writes (queued for a negedge monitor), the busy set and idle.
module tb_ysyx_25030093_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exu_valid = 1'b0, lsu_valid = 1'b0, issue_valid = 1'b0;
    logic [4:0]  exu_rd = '0, lsu_rd = '0, issue_rd = '0, rs1_addr = '0;
    logic [31:0] exu_data = '0, lsu_data = '0;
    logic        exu_ready, lsu_ready, rf_wen, rs1_busy, idle;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int compared = 0;
    int mismatched = 0;

    // reference model state
    int          last = 2;
    logic [31:0] busy_m = '0;
    logic        mwen = 1'b0;
    logic [4:0]  mwaddr = '0;
    logic [36:0] q[$];
    logic [36:0] e;

    ysyx_25030093_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1_addr(rs1_addr), .rs1_busy(rs1_busy), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // 0 none, 1 EXU, 2 LSU; on a tie the side not granted last wins
    function automatic int exp_grant();
        if (exu_valid && lsu_valid) return last == 1 ? 2 : 1;
        if (exu_valid) return 1;
        if (lsu_valid) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] next_busy();
        logic [31:0] nb = busy_m;
        if (mwen) nb[mwaddr] = 1'b0;
        if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
        return nb;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last   <= 2;
            busy_m <= '0;
            mwen   <= 1'b0;
            mwaddr <= '0;
            q.delete();
        end else begin
            busy_m <= next_busy();
            mwen   <= 1'b0;
            if (exp_grant() == 1) begin
                last   <= 1;
                mwen   <= exu_rd != 0;
                mwaddr <= exu_rd;
                if (exu_rd != 0) q.push_back({exu_rd, exu_data});
            end else if (exp_grant() == 2) begin
                last   <= 2;
                mwen   <= lsu_rd != 0;
                mwaddr <= lsu_rd;
                if (lsu_rd != 0) q.push_back({lsu_rd, lsu_data});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("rf_wen", {31'b0, rf_wen}, 32'd1);
                chk("rf_waddr", {27'b0, rf_waddr}, {27'b0, e[36:32]});
                chk("rf_wdata", rf_wdata, e[31:0]);
            end else begin
                chk("rf_wen_quiet", {31'b0, rf_wen}, 32'd0);
            end
        end
    end

    task automatic cyc(input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic iv, input logic [4:0] ird, input logic [4:0] ra,
                       output int g);
        @(negedge clk);
        exu_valid = ev; exu_rd = erd; exu_data = ed;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        issue_valid = iv; issue_rd = ird; rs1_addr = ra;
        #1;
        g = exp_grant();
        chk("exu_ready", {31'b0, exu_ready}, {31'b0, g == 1});
        chk("lsu_ready", {31'b0, lsu_ready}, {31'b0, g == 2});
        chk("rs1_busy", {31'b0, rs1_busy}, {31'b0, busy_m[ra]});
        chk("idle", {31'b0, idle}, {31'b0, busy_m == 0 && !mwen});
    endtask

    task automatic chk_all_clear();
        chk("rst_rf_wen", {31'b0, rf_wen}, 32'd0);
        chk("rst_idle", {31'b0, idle}, 32'd1);
        for (int i = 0; i < 32; i++) begin
            rs1_addr = i[4:0];
            #1;
            chk("rst_rs1_busy", {31'b0, rs1_busy}, 32'd0);
        end
    endtask

    initial begin
        int g;
        logic eh, lh;
        logic ev, lv;
        logic [4:0] erd, lrd;
        logic [31:0] ed, ld;
        // reset with both requesters asserted
        exu_valid = 1'b1; exu_rd = 5'd1; exu_data = 32'h1;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h2;
        repeat (3) @(negedge clk);
        #1;
        chk_all_clear();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("first_grant_exu", {31'b0, exu_ready}, 32'd1);
        chk("first_grant_lsu", {31'b0, lsu_ready}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        // single EXU write to x5
        cyc(0, 0, 0, 0, 0, 0, 1, 5, 5, g);
        cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, g);
        chk("busy5_after_issue", {31'b0, rs1_busy}, 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 5, g);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 5, g);
        chk("busy5_cleared", {31'b0, rs1_busy}, 32'd0);
        chk("idle_after_write", {31'b0, idle}, 32'd1);
        // contention: both held valid for 6 cycles, grants must alternate
        for (int i = 0; i < 6; i++) begin
            int prev;
            prev = g;
            cyc(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, g);
            if (i > 0) chk("alternate", g, prev == 1 ? 2 : 1);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        // x0 write from LSU
        cyc(0, 0, 0, 1, 0, 32'hFF, 0, 0, 0, g);
        chk("x0_ready", {31'b0, lsu_ready}, 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        chk("x0_busy", {31'b0, rs1_busy}, 32'd0);
        // set/clear collision on x7
        cyc(0, 0, 0, 0, 0, 0, 1, 7, 7, g);
        cyc(1, 7, 32'h77, 0, 0, 0, 0, 0, 7, g);
        cyc(0, 0, 0, 0, 0, 0, 1, 7, 7, g);
        chk("collide_wen", {31'b0, rf_wen}, 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 7, g);
        chk("collide_busy", {31'b0, rs1_busy}, 32'd1);
        chk("collide_idle", {31'b0, idle}, 32'd0);
        // mid-operation reset with a write in flight and x1..x3 pending
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, g);
        cyc(0, 0, 0, 0, 0, 0, 1, 2, 0, g);
        cyc(1, 9, 32'h99, 0, 0, 0, 1, 3, 0, g);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 2, g);
        chk("pre_reset_wen", {31'b0, rf_wen}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_clear();
        @(negedge clk);
        rst_n = 1'b1;
        // randomized traffic honouring the hold-until-transfer rule
        eh = 1'b0; lh = 1'b0;
        ev = 0; lv = 0; erd = 0; lrd = 0; ed = 0; ld = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!eh) begin
                ev = $urandom_range(0, 2) != 0; erd = 5'($urandom); ed = $urandom; eh = ev;
            end
            if (!lh) begin
                lv = $urandom_range(0, 2) != 0; lrd = 5'($urandom); ld = $urandom; lh = lv;
            end
            cyc(ev, erd, ed, lv, lrd, ld, 1'($urandom), 5'($urandom), 5'($urandom), g);
            if (g == 1) eh = 1'b0;
            if (g == 2) lh = 1'b0;
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        chk("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
